// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the pipelined control unit.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the control bundle and an illegal-opcode flag.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opCode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opCode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes in ID and carries controls through ID/EX, EX/MEM, MEM/WB.
// Define PIPE_CTRL_HAZARD_EN to compile in load-use hazard detection (stallOut).
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int REG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opCode,
  input  logic [REG_W-1:0]   idRs,
  input  logic [REG_W-1:0]   idRt,
  input  logic [REG_W-1:0]   idRd,
  input  logic               stallIn,
  input  logic               flushIn,
  output logic               exRegDst,
  output logic               exAluSrc,
  output logic               exBranch,
  output logic               exJump,
  output logic [ALUOP_W-1:0] exAluOp,
  output logic               memMemRead,
  output logic               memMemWrite,
  output logic               memBranch,
  output logic               wbMemToReg,
  output logic               wbRegWrite,
  output logic [REG_W-1:0]   wbDestReg,
  output logic               exValid,
  output logic               memValid,
  output logic               wbValid,
  output logic               exIllegal,
  output logic               stallOut
);

  ctrl_t            id_ctrl;
  logic             id_illegal;
  logic [REG_W-1:0] id_dest;

  ctrl_decode u_decode (
    .opCode  (opCode),
    .ctrl    (id_ctrl),
    .illegal (id_illegal)
  );

  assign id_dest = id_ctrl.reg_dst ? idRd : idRt;

  // ID/EX stage registers
  ctrl_t            ctrl_p0;
  logic             vld_p0;
  logic             ill_p0;
  logic [REG_W-1:0] dest_p0;

  // EX/MEM stage registers
  logic             m2r_p1;
  logic             rw_p1;
  logic             mr_p1;
  logic             mw_p1;
  logic             br_p1;
  logic             vld_p1;
  logic [REG_W-1:0] dest_p1;

  // MEM/WB stage registers
  logic             m2r_p2;
  logic             rw_p2;
  logic             vld_p2;
  logic [REG_W-1:0] dest_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_p0 <= CTRL_NOP;
      vld_p0  <= 1'b0;
      ill_p0  <= 1'b0;
      dest_p0 <= '0;
      m2r_p1  <= 1'b0;
      rw_p1   <= 1'b0;
      mr_p1   <= 1'b0;
      mw_p1   <= 1'b0;
      br_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      dest_p1 <= '0;
      m2r_p2  <= 1'b0;
      rw_p2   <= 1'b0;
      vld_p2  <= 1'b0;
      dest_p2 <= '0;
    end else if (!stallIn) begin
      // MEM/WB advances on both flush and load-use stall.
      m2r_p2  <= m2r_p1;
      rw_p2   <= rw_p1;
      vld_p2  <= vld_p1;
      dest_p2 <= dest_p1;
      if (flushIn) begin
        ctrl_p0 <= CTRL_NOP;
        vld_p0  <= 1'b0;
        ill_p0  <= 1'b0;
        dest_p0 <= '0;
        m2r_p1  <= 1'b0;
        rw_p1   <= 1'b0;
        mr_p1   <= 1'b0;
        mw_p1   <= 1'b0;
        br_p1   <= 1'b0;
        vld_p1  <= 1'b0;
        dest_p1 <= '0;
      end else begin
        m2r_p1  <= ctrl_p0.mem_to_reg;
        rw_p1   <= ctrl_p0.reg_write;
        mr_p1   <= ctrl_p0.mem_read;
        mw_p1   <= ctrl_p0.mem_write;
        br_p1   <= ctrl_p0.branch;
        vld_p1  <= vld_p0;
        dest_p1 <= dest_p0;
        if (stallOut) begin
          ctrl_p0 <= CTRL_NOP;
          vld_p0  <= 1'b0;
          ill_p0  <= 1'b0;
          dest_p0 <= '0;
        end else begin
          ctrl_p0 <= id_ctrl;
          vld_p0  <= 1'b1;
          ill_p0  <= id_illegal;
          dest_p0 <= id_dest;
        end
      end
    end
  end

`ifdef PIPE_CTRL_HAZARD_EN
  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = (dest_p0 == idRs);
  assign rt_hit   = (dest_p0 == idRt) && reads_rt(opCode);
  assign stallOut = vld_p0 && ctrl_p0.mem_read && (dest_p0 != '0) && (rs_hit || rt_hit);
`else
  logic unused_rs;

  assign unused_rs = ^idRs;
  assign stallOut  = 1'b0;
`endif

  assign exRegDst    = ctrl_p0.reg_dst;
  assign exAluSrc    = ctrl_p0.alu_src;
  assign exBranch    = ctrl_p0.branch;
  assign exJump      = ctrl_p0.jump;
  assign exAluOp     = ALUOP_W'(ctrl_p0.alu_op);
  assign exValid     = vld_p0;
  assign exIllegal   = ill_p0;

  assign memMemRead  = mr_p1 & vld_p1;
  assign memMemWrite = mw_p1 & vld_p1;
  assign memBranch   = br_p1 & vld_p1;
  assign memValid    = vld_p1;

  assign wbMemToReg  = m2r_p2;
  assign wbRegWrite  = rw_p2 & vld_p2;
  assign wbDestReg   = dest_p2;
  assign wbValid     = vld_p2;

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 SHALL have parameter ALUOP_W, default 2, the ALU-op field width (>=2; extra MSBs zero).
REQ-002 SHALL have parameter REG_W, default 5, the register-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port opCode, input, 6, the ID-stage instruction opcode.
REQ-006 SHALL have ports idRs/idRt/idRd, input, REG_W each, the ID-stage register fields.
REQ-007 SHALL have port stallIn, input, 1, external freeze of all stage registers.
REQ-008 SHALL have port flushIn, input, 1, taken branch/jump resolved in MEM.
REQ-009 SHALL have ports exRegDst, exAluSrc, exBranch, exJump (1 each) and exAluOp (ALUOP_W), output, EX-stage controls.
REQ-010 SHALL have ports memMemRead, memMemWrite, memBranch, output, 1 each, MEM-stage controls.
REQ-011 SHALL have ports wbMemToReg, wbRegWrite (1 each) and wbDestReg (REG_W), output, WB-stage controls.
REQ-012 SHALL have ports exValid/memValid/wbValid, output, 1 each, stage-occupied flags.
REQ-013 SHALL have port exIllegal, output, 1, EX-stage instruction had an undefined opcode.
REQ-014 SHALL have port stallOut, output, 1, combinational load-use stall request to PC and IF/ID.

Function
REQ-015 SHALL decode (regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,aluOp,jump): 000000 R -> 1,0,0,1,0,0,0,10,0; 100011 LW -> 0,1,1,1,1,0,0,00,0; 101011 SW -> 0,1,0,0,0,1,0,00,0; 001000 ADDI -> 0,1,0,1,0,0,0,00,0; 000100 BEQ -> 0,0,0,0,0,0,1,01,0; 000010 J -> all 0, jump=1.
REQ-016 SHALL decode any other opcode as all controls 0, valid=1, illegal=1.
REQ-017 SHALL compute destination register as regDst ? idRd : idRt and carry it through ID/EX, EX/MEM, MEM/WB.
REQ-018 SHALL give one cycle latency per stage: a decoded instruction appears on ex* one cycle, mem* two cycles, wb* three cycles after sampling.
REQ-019 SHALL, per edge, apply priority rst > stallIn > flushIn > stallOut > normal advance.
REQ-020 SHALL, with stallIn=1, hold every stage register unchanged (stallOut still evaluated).
REQ-021 SHALL, with flushIn=1, load bubbles (all controls 0, valid 0, illegal 0) into ID/EX and EX/MEM while MEM/WB advances normally.
REQ-022 SHALL, with stallOut=1, load a bubble into ID/EX while EX/MEM and MEM/WB advance.
REQ-023 SHALL treat a bubble as never writing memory or registers; wbRegWrite=1 only with wbValid=1.

Reset
REQ-024 SHALL, on rst at a clock edge, clear every stage register: all outputs 0, all valid flags 0, exIllegal 0, wbDestReg 0.
REQ-025 SHALL let rst asserted mid-operation override stallIn/flushIn on the same edge; in-flight instructions are discarded.

Configuration
REQ-026 SHALL use macro PIPE_CTRL_HAZARD_EN to compile in load-use detection.
REQ-027 SHALL, with PIPE_CTRL_HAZARD_EN defined, drive stallOut = exValid & memRead_ex & (exDest!=0) & (exDest==idRs | (exDest==idRt & ID opcode in {R,SW,BEQ})).
REQ-028 SHALL, without PIPE_CTRL_HAZARD_EN, tie stallOut to 0 and omit the comparators.

Structure
REQ-029 SHALL place opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J), ALU-op encodings and the control-bundle struct/typedef in shared package pipe_ctrl_pkg.
REQ-030 SHALL instantiate one combinational sub-module ctrl_decode (opCode -> control bundle + illegal); pipeline registers and hazard logic stay in pipe_control_unit.

Verification
REQ-031 SHALL cover: rst=1 one edge with opCode=100011 -> all outputs 0, valid flags 0.
REQ-032 SHALL cover: sequence R,LW,SW,ADDI,BEQ,J,111111 one per cycle -> ex* matches REQ-015 table one cycle later, exIllegal=1 only for 111111, wbRegWrite=1 for R/LW/ADDI three cycles later.
REQ-033 SHALL cover: LW with idRt=8, next ID R-type with idRs=8 (macro on) -> stallOut=1 one cycle, bubble in EX, R reaches EX one cycle later; macro off -> stallOut=0.
REQ-034 SHALL cover: LW dest 0 followed by R using rs=0 -> stallOut=0.
REQ-035 SHALL cover: flushIn=1 while BEQ in MEM and two instructions behind -> exValid=0, memValid=0 next cycle, wb reflects BEQ.
REQ-036 SHALL cover: stallIn=1 for 3 cycles with ADDI in EX -> all outputs constant, then resume advancing.
